// File: rtl/instr_cache_refill_ctrl.sv
// ============================================================================
// instr_cache_refill_ctrl
//
// Refill engine for the instruction cache data array. On a refill request it
// fetches one cache block from memory as 32-bit beats, one outstanding read at
// a time. It packs each group of four beats into a 128-bit row and writes that
// row through the flush port with a single active-low strobe. After the last
// row it pulses done for one cycle.
//
// Ports
//   clk_i               : clock
//   rst_i               : synchronous reset, active-low
//   refill_req_i        : start a refill (sampled in IDLE only)
//   refill_base_addr_i  : block byte address (block-offset bits ignored)
//   refill_busy_o       : refill in progress (request accepted .. done cycle)
//   refill_done_o       : one-cycle completion pulse
//   mem_req_o           : read request, held until granted
//   mem_addr_o          : word-aligned byte address of the current beat
//   mem_gnt_i           : request accepted this cycle
//   mem_rvalid_i        : read data valid
//   mem_rdata_i         : read data
//   flush_data_o        : row buffer, lane k = word offset 4*row+k
//   flushing_n_o        : active-low per-row write strobe (at most one low)
// ============================================================================
module instr_cache_refill_ctrl #(
    parameter int ADDR_WIDTH     = 5,
    parameter int MEM_ADDR_WIDTH = 32
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              refill_req_i,
    input  logic [MEM_ADDR_WIDTH-1:0]         refill_base_addr_i,
    output logic                              refill_busy_o,
    output logic                              refill_done_o,
    output logic                              mem_req_o,
    output logic [MEM_ADDR_WIDTH-1:0]         mem_addr_o,
    input  logic                              mem_gnt_i,
    input  logic                              mem_rvalid_i,
    input  logic [31:0]                       mem_rdata_i,
    output logic [127:0]                      flush_data_o,
    output logic [(2**(ADDR_WIDTH-2))-1:0]    flushing_n_o
);

    localparam int ROWS   = 2 ** (ADDR_WIDTH - 2);
    localparam int DATA_W = 32;
    // Byte-offset bits covered by one block; these are forced to zero in the base.
    localparam int OFS_W  = ADDR_WIDTH + 2;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        WRITE,
        DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     word_idx_q, word_idx_d;
    logic [MEM_ADDR_WIDTH-1:0] base_q, base_d;
    logic [127:0]              row_q, row_d;

    // The block-offset bits of the requested base are intentionally dropped.
    logic unused_base_ofs;
    assign unused_base_ofs = ^refill_base_addr_i[OFS_W-1:0];

    // Block-aligned base plus word offset; wraps naturally at the bus width.
    assign mem_addr_o    = base_q + MEM_ADDR_WIDTH'({word_idx_q, 2'b00});
    assign flush_data_o  = row_q;
    assign refill_busy_o = (state_q != IDLE);

    always_comb begin
        state_d       = state_q;
        word_idx_d    = word_idx_q;
        base_d        = base_q;
        row_d         = row_q;
        mem_req_o     = 1'b0;
        refill_done_o = 1'b0;
        flushing_n_o  = '1;

        unique case (state_q)
            IDLE: begin
                if (refill_req_i) begin
                    base_d     = {refill_base_addr_i[MEM_ADDR_WIDTH-1:OFS_W], {OFS_W{1'b0}}};
                    word_idx_d = '0;
                    state_d    = REQ;
                end
            end

            REQ: begin
                mem_req_o = 1'b1;
                if (mem_gnt_i) begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (mem_rvalid_i) begin
                    row_d[{word_idx_q[1:0], 5'b00000} +: DATA_W] = mem_rdata_i;
                    // The fourth beat completes the row; the index is kept on
                    // that beat so WRITE can still see which row it belongs to.
                    if (word_idx_q[1:0] == 2'b11) begin
                        state_d = WRITE;
                    end else begin
                        word_idx_d = word_idx_q + ADDR_WIDTH'(1);
                        state_d    = REQ;
                    end
                end
            end

            WRITE: begin
                flushing_n_o[word_idx_q[ADDR_WIDTH-1:2]] = 1'b0;
                if (&word_idx_q) begin
                    state_d = DONE;
                end else begin
                    word_idx_d = word_idx_q + ADDR_WIDTH'(1);
                    state_d    = REQ;
                end
            end

            DONE: begin
                refill_done_o = 1'b1;
                state_d       = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            word_idx_q <= '0;
            base_q     <= '0;
            row_q      <= '0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            base_q     <= base_d;
            row_q      <= row_d;
        end
    end

endmodule

// File: tb/tb_instr_cache_refill_ctrl.sv
// ============================================================================
// tb_instr_cache_refill_ctrl
//
// Self-checking bench for instr_cache_refill_ctrl (default parameters).
// The bench acts as the memory. It answers each request with data derived from
// the address, and it can stall the grant or delay rvalid per beat. Expected
// rows, addresses and latency come from the block arithmetic:
//   - row r of block B holds mem(B+16r+4k) in lane k;
//   - beat b is fetched from B+4b;
//   - latency is 73 plus every stall and rvalid-delay cycle.
// A fixed table covers the directed cases. Hand-written sequences cover reset
// mid-refill. Randomized refills are then checked against the same model.
// ============================================================================
module tb_instr_cache_refill_ctrl;

    localparam int AW    = 5;
    localparam int MAW   = 32;
    localparam int ROWS  = 8;
    localparam int BEATS = 32;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            refill_req_i;
    logic [MAW-1:0]  refill_base_addr_i;
    logic            refill_busy_o;
    logic            refill_done_o;
    logic            mem_req_o;
    logic [MAW-1:0]  mem_addr_o;
    logic            mem_gnt_i;
    logic            mem_rvalid_i;
    logic [31:0]     mem_rdata_i;
    logic [127:0]    flush_data_o;
    logic [ROWS-1:0] flushing_n_o;

    always #5 clk = ~clk;

    instr_cache_refill_ctrl #(
        .ADDR_WIDTH     (AW),
        .MEM_ADDR_WIDTH (MAW)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .refill_req_i       (refill_req_i),
        .refill_base_addr_i (refill_base_addr_i),
        .refill_busy_o      (refill_busy_o),
        .refill_done_o      (refill_done_o),
        .mem_req_o          (mem_req_o),
        .mem_addr_o         (mem_addr_o),
        .mem_gnt_i          (mem_gnt_i),
        .mem_rvalid_i       (mem_rvalid_i),
        .mem_rdata_i        (mem_rdata_i),
        .flush_data_o       (flush_data_o),
        .flushing_n_o       (flushing_n_o)
    );

    int          chk_cnt  = 0;
    int          pass_cnt = 0;
    logic [31:0] salt     = 32'h0;
    int          cfg_stall [BEATS];
    int          cfg_rvd   [BEATS];

    typedef struct packed {
        logic [31:0]  base;
        int           stall_beat;
        int           stall_len;
        int           rvd;
        bit           hold;
        logic [31:0]  exp_first;
        logic [31:0]  exp_last;
        logic [127:0] exp_row0;
        int           exp_lat;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ salt;
    endfunction

    function automatic logic [127:0] row_model(input logic [31:0] blk, input int r);
        logic [127:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) v[32*k +: 32] = mem_word(blk + 32'(16*r + 4*k));
        return v;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, 192'({mem_req_o, refill_busy_o, refill_done_o, flushing_n_o}),
              192'({1'b0, 1'b0, 1'b0, 8'hFF}));
        check({tag, "_addr"}, 192'(mem_addr_o), 192'(32'h0));
        check({tag, "_data"}, 192'(flush_data_o), 192'(128'h0));
    endtask

    // One refill with the bench acting as memory. cfg_stall/cfg_rvd give the
    // grant stall and rvalid delay of each beat. abort_beats>0 drives reset
    // low right after that many beats have been returned.
    task automatic do_refill(input logic [31:0] base, input bit hold, input int abort_beats,
                             input bit noise, input logic [31:0] exp_first,
                             input logic [31:0] exp_last, input int exp_lat,
                             input bit chk_row0, input logic [127:0] exp_row0);
        int done_t, done_cnt, beat, stall_cnt, delivered, pwait, last_wr_t;
        int addr_err, proto_err, fl_err, req_cyc, exp_req_cyc, exp_writes;
        bit pending, finished, aborted, busy_at_done, busy_after, busy_restart;
        logic [31:0] paddr, first_a, last_a;
        logic [ROWS-1:0] one;
        logic [ROWS-1:0] wr_fl [$];
        logic [127:0] wr_dat [$];

        done_t = -1; done_cnt = 0; beat = 0; stall_cnt = 0; delivered = 0; pwait = 0;
        last_wr_t = -100; addr_err = 0; proto_err = 0; fl_err = 0; req_cyc = 0;
        pending = 0; finished = 0; aborted = 0; busy_at_done = 0; busy_after = 1'b1;
        busy_restart = 0; paddr = '0; first_a = '0; last_a = '0; one = 1;
        exp_req_cyc = BEATS;
        for (int b = 0; b < BEATS; b++) exp_req_cyc += cfg_stall[b];

        refill_req_i = 1'b1;
        refill_base_addr_i = base;
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0;

        for (int t = 1; t <= 3000 && !finished && !aborted; t++) begin
            @(posedge clk);
            #1;
            if (t == 1) check("accept", 192'({refill_busy_o, mem_req_o}), 192'(2'b11));
            if (abort_beats > 0 && delivered == abort_beats) begin
                rst_i = 1'b0;
                refill_req_i = 1'b0;
                mem_gnt_i = 1'b0;
                mem_rvalid_i = 1'b0;
                aborted = 1'b1;
            end else begin
                if (flushing_n_o != '1) begin
                    wr_fl.push_back(flushing_n_o);
                    wr_dat.push_back(flush_data_o);
                    last_wr_t = t;
                    if ($countones(~flushing_n_o) != 1) fl_err++;
                end
                if (refill_done_o) begin
                    done_cnt++;
                    if (done_t < 0) done_t = t;
                end
                if (done_t < 0 || t == done_t) begin
                    if (!refill_busy_o) proto_err++;
                    busy_at_done = refill_busy_o;
                end
                if (done_t >= 0 && t == done_t + 1) busy_after = refill_busy_o;
                if (done_t >= 0 && t == done_t + 2) begin
                    busy_restart = refill_busy_o;
                    finished = 1'b1;
                end else begin
                    if (mem_req_o) req_cyc++;
                    refill_base_addr_i = $urandom;
                    if (hold) refill_req_i = 1'b1;
                    else if (done_t >= 0) refill_req_i = 1'b0;
                    else refill_req_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                    mem_gnt_i = 1'b0;
                    mem_rvalid_i = 1'b0;
                    mem_rdata_i = $urandom;
                    if (pending) begin
                        if (mem_req_o) proto_err++;
                        if (pwait == 0) begin
                            mem_rvalid_i = 1'b1;
                            mem_rdata_i = mem_word(paddr);
                            pending = 1'b0;
                            delivered++;
                        end else begin
                            pwait--;
                        end
                    end else if (mem_req_o) begin
                        if (beat >= BEATS) begin
                            proto_err++;
                        end else begin
                            if (mem_addr_o != exp_first + 32'(4*beat)) addr_err++;
                            if (stall_cnt < cfg_stall[beat]) begin
                                stall_cnt++;
                                mem_rvalid_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                            end else begin
                                mem_gnt_i = 1'b1;
                                pending = 1'b1;
                                paddr = mem_addr_o;
                                pwait = cfg_rvd[beat];
                                if (beat == 0) first_a = mem_addr_o;
                                last_a = mem_addr_o;
                                beat++;
                                stall_cnt = 0;
                            end
                        end
                    end
                end
            end
        end

        if (!aborted) begin
            refill_req_i = 1'b0;
            mem_gnt_i = 1'b0;
            mem_rvalid_i = 1'b0;
        end
        exp_writes = aborted ? abort_beats / 4 : ROWS;
        check("nwrites", 192'(wr_fl.size()), 192'(exp_writes));
        for (int r = 0; r < exp_writes; r++) begin
            if (r < wr_fl.size())
                check($sformatf("row%0d", r), 192'({wr_fl[r], wr_dat[r]}),
                      192'({~(one << r), row_model(exp_first, r)}));
        end
        check("single_low", 192'(fl_err), 192'(0));
        check("addr_seq", 192'(addr_err), 192'(0));
        check("protocol", 192'(proto_err), 192'(0));
        if (aborted) begin
            check("no_done_abort", 192'(done_cnt), 192'(0));
        end else begin
            check("completed", 192'(finished), 192'(1));
            check("first_addr", 192'(first_a), 192'(exp_first));
            check("last_addr", 192'(last_a), 192'(exp_last));
            check("req_cycles", 192'(req_cyc), 192'(exp_req_cyc));
            check("latency", 192'(done_t), 192'(exp_lat));
            check("done_count", 192'(done_cnt), 192'(1));
            check("done_after_write", 192'(done_t - last_wr_t), 192'(1));
            check("busy_fall", 192'({busy_at_done, busy_after}), 192'(2'b10));
            check("restart", 192'(busy_restart), 192'(hold));
            if (chk_row0 && wr_dat.size() > 0) check("row0_const", 192'(wr_dat[0]), 192'(exp_row0));
            if (hold || !finished) begin
                rst_i = 1'b0;
                @(posedge clk);
                #1;
                rst_i = 1'b1;
            end
        end
    endtask

    initial begin
        int sum_extra;
        logic [31:0] b;
        int stray_err;

        vecs[0] = '{32'h0000_1000, -1, 0, 0, 1'b0, 32'h0000_1000, 32'h0000_107C,
                    128'h0000100C_00001008_00001004_00001000, 73};
        vecs[1] = '{32'h0000_107C, -1, 0, 0, 1'b0, 32'h0000_1000, 32'h0000_107C,
                    128'h0000100C_00001008_00001004_00001000, 73};
        vecs[2] = '{32'h0000_1000, 5, 3, 0, 1'b0, 32'h0000_1000, 32'h0000_107C,
                    128'h0000100C_00001008_00001004_00001000, 76};
        vecs[3] = '{32'hFFFF_FF80, -1, 0, 0, 1'b0, 32'hFFFF_FF80, 32'hFFFF_FFFC,
                    128'hFFFFFF8C_FFFFFF88_FFFFFF84_FFFFFF80, 73};
        vecs[4] = '{32'h0000_3000, -1, 0, 0, 1'b1, 32'h0000_3000, 32'h0000_307C,
                    128'h0000300C_00003008_00003004_00003000, 73};
        vecs[5] = '{32'h0000_0200, -1, 0, 2, 1'b0, 32'h0000_0200, 32'h0000_027C,
                    128'h0000020C_00000208_00000204_00000200, 137};

        rst_i = 1'b0;
        refill_req_i = 1'b0;
        refill_base_addr_i = '0;
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_i = 1'b1;
        @(posedge clk);
        #1;

        // Directed table: data equals address.
        salt = 32'h0;
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < BEATS; k++) begin
                cfg_stall[k] = (k == vecs[i].stall_beat) ? vecs[i].stall_len : 0;
                cfg_rvd[k]   = vecs[i].rvd;
            end
            do_refill(vecs[i].base, vecs[i].hold, 0, 1'b0, vecs[i].exp_first,
                      vecs[i].exp_last, vecs[i].exp_lat, 1'b1, vecs[i].exp_row0);
        end

        // Reset after six beats: row 0 written, row 1 half full.
        for (int k = 0; k < BEATS; k++) begin
            cfg_stall[k] = 0;
            cfg_rvd[k]   = 0;
        end
        do_refill(32'h0000_4000, 1'b0, 6, 1'b0, 32'h0000_4000, 32'h0000_407C, 73, 1'b0, '0);
        @(posedge clk);
        #1;
        check_reset_outputs("abort_reset");
        rst_i = 1'b1;
        stray_err = 0;
        for (int k = 0; k < 4; k++) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i = $urandom;
            @(posedge clk);
            #1;
            if (flushing_n_o != '1 || refill_done_o || refill_busy_o || mem_req_o) stray_err++;
        end
        mem_rvalid_i = 1'b0;
        check("stray_rvalid", 192'(stray_err), 192'(0));

        // Randomized refills with stalls, rvalid delays and input noise.
        for (int n = 0; n < 12; n++) begin
            salt = $urandom;
            b = $urandom;
            sum_extra = 0;
            for (int k = 0; k < BEATS; k++) begin
                cfg_stall[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                cfg_rvd[k]   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
                sum_extra += cfg_stall[k] + cfg_rvd[k];
            end
            do_refill(b, 1'($urandom_range(0, 3) == 0), 0, 1'b1, b & 32'hFFFF_FF80,
                      (b & 32'hFFFF_FF80) + 32'h7C, 73 + sum_extra, 1'b0, '0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/instr_cache_refill_ctrl.md
# instr_cache_refill_ctrl

Refill engine on the memory side of the instruction cache data array. On a miss it reads one cache block from memory as 32-bit beats and packs each group of four beats into a 128-bit quadword row. It writes each row into the data array through the flush port `flush_data` / `flushing_n`, one row per write. It then reports completion to the cache control logic.

## Interface
Parameters:
- `ADDR_WIDTH`, default 5: word-address width inside one cache block. A block holds 2^ADDR_WIDTH words, and ROWS = 2^(ADDR_WIDTH-2).
- `MEM_ADDR_WIDTH`, default 32: byte-address width of the memory bus.

Ports:
- `clk_i` in 1: the only clock; every port is synchronous to it.
- `rst_i` in 1: reset, synchronous and active-low.
- `refill_req_i` in 1: start a refill. Sampled in IDLE only.
- `refill_base_addr_i` in MEM_ADDR_WIDTH: block byte address. Bits [ADDR_WIDTH+1:0] are ignored and treated as 0.
- `refill_busy_o` out 1: high from the cycle after the request is accepted until the cycle after the done pulse.
- `refill_done_o` out 1: one-cycle pulse after the last row is written.
- `mem_req_o` out 1: read request, held until granted.
- `mem_addr_o` out MEM_ADDR_WIDTH: word-aligned byte address of the current beat.
- `mem_gnt_i` in 1: memory accepts the request in the same cycle `mem_req_o` is high.
- `mem_rvalid_i` in 1: read data valid.
- `mem_rdata_i` in 32: read data.
- `flush_data_o` out 128: row data. Lane k occupies bits [32k+31:32k] and holds word offset 4·row+k.
- `flushing_n_o` out ROWS: active-low per-row write enable. At most one bit is low in any cycle.

## Operation
- FSM states: IDLE, REQ, WAIT, WRITE, DONE.
- IDLE:
  - If `refill_req_i`=1, latch the aligned base, clear `word_idx` (ADDR_WIDTH bits), and go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - `mem_req_o`=1 and `mem_addr_o` = base + 4·word_idx, taken modulo 2^MEM_ADDR_WIDTH.
  - Address stays stable until `mem_gnt_i`=1, then go to WAIT.
  - `mem_rvalid_i` is ignored in REQ.
- WAIT:
  - `mem_req_o`=0.
  - On `mem_rvalid_i`=1, store `mem_rdata_i` into lane word_idx[1:0] of the row buffer.
  - If word_idx[1:0]=3, go to WRITE. Otherwise increment `word_idx` and go to REQ.
- WRITE (one cycle):
  - `flushing_n_o[word_idx[ADDR_WIDTH-1:2]]`=0; all other bits are 1.
  - `flush_data_o` equals the full row buffer.
  - If `word_idx` is all ones, go to DONE. Otherwise increment `word_idx` and go to REQ.
- DONE (one cycle): `refill_done_o`=1, then go to IDLE.
- `flush_data_o` always reflects the row buffer. It may change outside WRITE; it is only meaningful while a `flushing_n_o` bit is low.
- `refill_req_i` outside IDLE is ignored. It is neither queued nor allowed to corrupt the latched base.
- Rows are written in ascending order 0..ROWS-1. Each row is written exactly once per refill.

## Timing
- Reset values: `mem_req_o`=0, `mem_addr_o`=0, `flush_data_o`=0, `flushing_n_o`=all ones, `refill_busy_o`=0, `refill_done_o`=0. FSM goes to IDLE and `word_idx`=0.
- Reset mid-refill:
  - Next cycle returns to reset values. No partial row is written and `refill_done_o` does not pulse.
  - A late `mem_rvalid_i` after reset is ignored.
- Request acceptance:
  - `refill_req_i` high in IDLE at edge N gives `refill_busy_o`=1 and `mem_req_o`=1 at edge N+1.
- Bus:
  - One outstanding read at a time.
  - `mem_rvalid_i` comes at least one cycle after grant.
  - Minimum 2 cycles per beat, with `mem_gnt_i` in the first REQ cycle and `mem_rvalid_i` in the first WAIT cycle.
- Row write: the `flushing_n_o` low pulse comes 1 cycle after the 4th beat of the row is captured.
- Full-refill latency with a zero-wait bus, default parameters:
  - 1 (IDLE→REQ) + 8 rows × (4×2 + 1) = 73 cycles from the request edge to the DONE cycle.
  - `refill_busy_o` falls on the cycle after DONE.
- `refill_done_o` and the final `flushing_n_o` pulse never overlap; they come in consecutive cycles.

## Test plan
- Zero-wait refill, base 0x0000_1000, memory returns data = address:
  - Eight `flushing_n_o` pulses, rows 0..7 in order.
  - Row 0 `flush_data_o` = {0x100C,0x1008,0x1004,0x1000}.
  - `refill_done_o` pulses 73 cycles after the request.
- Unaligned base 0x0000_107C:
  - First `mem_addr_o` = 0x0000_1000.
  - Last = 0x0000_107C.
- Grant stall of 3 cycles on beat 5:
  - `mem_req_o` and `mem_addr_o`=base+0x14 held for 4 cycles.
  - Data is still correct and latency grows by 3.
- `refill_req_i` held high during a busy refill:
  - Exactly one refill completes.
  - A second refill starts only from IDLE, if the request is still high there.
- `rst_i`=0 after beat 6 (row 1 incomplete):
  - Next cycle, all outputs are at reset values and `flushing_n_o` stays all ones.
  - A stray `mem_rvalid_i` afterwards causes no write.
- Wrap: base 0xFFFF_FF80:
  - Addresses run 0xFFFF_FF80..0xFFFF_FFFC with no carry out.
  - Done pulse as normal.
